// File: rtl/wb_master_bridge.sv
// Single-outstanding Wishbone classic initiator driven by a valid/ready command stream.
// Each command becomes one Wishbone cycle; a response carries read data or a timeout flag.
module wb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [ADDR_W-1:0]   cmd_adr_i,
  input  logic [DATA_W-1:0]   cmd_dat_i,
  input  logic [DATA_W/8-1:0] cmd_sel_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_dat_o,
  output logic                rsp_err_o,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [DATA_W/8-1:0] wbm_sel_o,
  output logic [ADDR_W-1:0]   wbm_adr_o,
  output logic [DATA_W-1:0]   wbm_dat_o,
  input  logic                wbm_ack_i,
  input  logic [DATA_W-1:0]   wbm_dat_i,
  output logic                busy_o
);

  localparam int SEL_W = DATA_W / 8;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t              state_q, state_d;
  logic                cyc_q, cyc_d;
  logic                we_q, we_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_dat_q, rsp_dat_d;
  logic                rsp_err_q, rsp_err_d;
  logic [15:0]         cnt_q, cnt_d;

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          we_d    = cmd_we_i;
          sel_d   = cmd_sel_i;
          adr_d   = cmd_adr_i;
          dat_d   = cmd_dat_i;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        // An ack on the final allowed cycle takes priority over the timeout.
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = we_q ? '0 : wbm_dat_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (cnt_q == CNT_LAST) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        cyc_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge: one instance with TIMEOUT=8, one with TIMEOUT=3.
module tb_wb_master_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;

  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        cyc, stb, we, ack, busy;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o, dat_i;

  logic        cmd_valid_b, cmd_ready_b, rsp_valid_b, rsp_ready_b, rsp_err_b;
  logic [31:0] rsp_dat_b;
  logic        cyc_b, stb_b, we_b, ack_b, busy_b;
  logic [3:0]  sel_b;
  logic [31:0] adr_b, dat_o_b, dat_i_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_ack_i(ack), .wbm_dat_i(dat_i),
    .busy_o(busy)
  );

  wb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(3)) dut3 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid_b), .cmd_ready_o(cmd_ready_b), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid_b), .rsp_ready_i(rsp_ready_b), .rsp_dat_o(rsp_dat_b), .rsp_err_o(rsp_err_b),
    .wbm_cyc_o(cyc_b), .wbm_stb_o(stb_b), .wbm_we_o(we_b), .wbm_sel_o(sel_b),
    .wbm_adr_o(adr_b), .wbm_dat_o(dat_o_b), .wbm_ack_i(ack_b), .wbm_dat_i(dat_i_b),
    .busy_o(busy_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0; ack = 1'b0; dat_i = '0;
    cmd_valid_b = 1'b0; rsp_ready_b = 1'b0; ack_b = 1'b0; dat_i_b = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("reset_bus", {cyc, stb, we, sel, adr, dat_o}, {3'b000, 4'h0, 32'h0, 32'h0});
    chk("reset_rsp", {rsp_valid, rsp_err, rsp_dat}, {2'b00, 32'h0});
    chk("reset_ctl", {busy, cmd_ready, busy_b, cmd_ready_b}, 4'b0101);
    $display("[TB] reset checked");

    // Zero-wait read
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0004; cmd_sel = 4'hF; cmd_dat = 32'h0;
    tick();
    cmd_valid = 1'b0;
    chk("zw_stb", {cyc, stb, busy, cmd_ready}, 4'b1110);
    chk("zw_bus", {we, sel, adr}, {1'b0, 4'hF, 32'h3000_0004});
    ack = 1'b1; dat_i = 32'hA5A5_1234;
    tick();
    ack = 1'b0;
    chk("zw_rsp", {cyc, stb, rsp_valid, rsp_err, rsp_dat}, {4'b0010, 32'hA5A5_1234});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("zw_done", {rsp_valid, rsp_err, rsp_dat, cmd_ready, busy}, {2'b00, 32'h0, 2'b10});
    $display("[TB] zero-wait read done");

    // Wait-state write: stb high 5 cycles, bus fields stable
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0010; cmd_dat = 32'hDEAD_BEEF; cmd_sel = 4'h3;
    tick();
    cmd_valid = 1'b0; cmd_adr = 32'h0; cmd_dat = 32'h0; cmd_sel = 4'h0; cmd_we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("ws_hold", {cyc, stb, we, sel, adr, dat_o, rsp_valid},
          {3'b111, 4'h3, 32'h3000_0010, 32'hDEAD_BEEF, 1'b0});
      if (i == 4) begin
        ack = 1'b1; dat_i = 32'hFFFF_FFFF;
      end
      tick();
    end
    ack = 1'b0;
    chk("ws_rsp", {cyc, stb, rsp_valid, rsp_err, rsp_dat}, {4'b0010, 32'h0});
    chk("ws_idle_hold", {we, sel, adr, dat_o}, {1'b1, 4'h3, 32'h3000_0010, 32'hDEAD_BEEF});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    $display("[TB] wait-state write done");

    // Timeout: stb exactly 8 cycles, late ack ignored
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0020; cmd_sel = 4'hF;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("to_stb", {cyc, stb, rsp_valid}, 3'b110);
      tick();
    end
    chk("to_rsp", {cyc, stb, rsp_valid, rsp_err, rsp_dat}, {4'b0011, 32'h0});
    ack = 1'b1; dat_i = 32'h1234_5678;
    tick();
    ack = 1'b0;
    chk("to_late_ack", {cyc, stb, rsp_valid, rsp_err, rsp_dat, busy}, {4'b0011, 32'h0, 1'b1});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("to_done", {rsp_valid, rsp_err, cmd_ready}, 3'b001);
    $display("[TB] timeout done");

    // Response backpressure with a queued command
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0008; cmd_sel = 4'hF;
    tick();
    cmd_valid = 1'b0;
    ack = 1'b1; dat_i = 32'hCAFE_0001;
    tick();
    ack = 1'b0; dat_i = 32'h0;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_000C; cmd_dat = 32'h1122_3344; cmd_sel = 4'hF;
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", {rsp_valid, rsp_err, rsp_dat, cmd_ready, stb}, {2'b10, 32'hCAFE_0001, 2'b00});
      tick();
    end
    chk("bp_adr_hold", {adr, we}, {32'h3000_0008, 1'b0});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_handshake", {rsp_valid, cmd_ready, stb}, 3'b010);
    tick();
    cmd_valid = 1'b0;
    chk("bp_accept", {stb, we, adr, dat_o}, {2'b11, 32'h3000_000C, 32'h1122_3344});
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("bp_wr_rsp", {rsp_valid, rsp_err, rsp_dat}, {2'b10, 32'h0});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    $display("[TB] backpressure done");

    // TIMEOUT=3: ack on the 3rd stb cycle wins
    cmd_valid_b = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0050; cmd_sel = 4'hF;
    tick();
    cmd_valid_b = 1'b0;
    chk("co_stb1", {stb_b, rsp_valid_b}, 2'b10);
    tick();
    chk("co_stb2", {stb_b, rsp_valid_b}, 2'b10);
    tick();
    chk("co_stb3", {stb_b, rsp_valid_b}, 2'b10);
    ack_b = 1'b1; dat_i_b = 32'h0000_0077;
    tick();
    ack_b = 1'b0;
    chk("co_rsp", {stb_b, rsp_valid_b, rsp_err_b, rsp_dat_b}, {3'b010, 32'h0000_0077});
    rsp_ready_b = 1'b1;
    tick();
    rsp_ready_b = 1'b0;
    $display("[TB] coincident ack done");

    // TIMEOUT=3 without ack: stb exactly 3 cycles
    cmd_valid_b = 1'b1; cmd_adr = 32'h3000_0054;
    tick();
    cmd_valid_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t3_stb", {stb_b, rsp_valid_b}, 2'b10);
      tick();
    end
    chk("t3_rsp", {stb_b, rsp_valid_b, rsp_err_b, rsp_dat_b}, {3'b011, 32'h0});
    rsp_ready_b = 1'b1;
    tick();
    rsp_ready_b = 1'b0;
    $display("[TB] timeout=3 done");

    // Reset during BUS
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0030; cmd_sel = 4'hF;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("rst_pre", {stb, busy}, 2'b11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid", {cyc, stb, rsp_valid, busy, cmd_ready}, 5'b00001);
    cmd_valid = 1'b1; cmd_adr = 32'h3000_0040;
    tick();
    cmd_valid = 1'b0;
    chk("rst_next_stb", {stb, adr}, {1'b1, 32'h3000_0040});
    tick();
    chk("rst_next_wait", {stb, rsp_valid}, 2'b10);
    ack = 1'b1; dat_i = 32'h5555_AAAA;
    tick();
    ack = 1'b0;
    chk("rst_next_rsp", {stb, rsp_valid, rsp_err, rsp_dat}, {3'b010, 32'h5555_AAAA});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    $display("[TB] reset mid-cycle done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
